phaser_cfg: RTL and testbench

- Parametrised next-generation phase generator for the CPU bus.
- Derives CPHI2, a delayed VPHI2 and the bus-timing strobes from clk6x.
- Low/high phase lengths and VPHI2 offset are runtime-programmable; a stretch request holds CPHI2 high for slow devices.
- Sits between the NORA bus controller (run, stretch, cfg) and the CPU/VIA clock pins and CS logic.

---
 rtl/phaser_pkg.sv | 28 ++
 rtl/phase_delay.sv | 36 +++
 rtl/phaser_cfg.sv | 174 +++++++++++++++++
 tb/tb_phaser_cfg.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/phaser_pkg.sv
// Shared state encoding, timing defaults and configuration clamp helpers for the
// CPU/VIA phase generator.
package phaser_pkg;

   localparam logic ST_LO = 1'b0;
   localparam logic ST_HI = 1'b1;

   localparam int VOFS_W      = 3;
   localparam int DELAY_LEN   = 8;

   localparam int PH_DEF_LO   = 3;
   localparam int PH_DEF_HI   = 3;
   localparam int PH_DEF_VOFS = 1;

   function automatic int clamp_range(input int v, input int lo_lim, input int hi_lim);
      if (v < lo_lim) return lo_lim;
      if (v > hi_lim) return hi_lim;
      return v;
   endfunction

   // vphi2 must fall back inside the shorter phase, so its offset is capped at min(lo,hi)-1.
   function automatic int vofs_limit(input int lo, input int hi);
      int m;
      m = (lo < hi) ? lo : hi;
      return clamp_range(m - 1, 0, DELAY_LEN - 1);
   endfunction

endpackage

// File: rtl/phase_delay.sv
// vphi2 delay line: eight taps, tap 0 is cphi2 itself and tap k is cphi2 delayed k clk6x.
// Resets to all ones so vphi2 starts high.
module phase_delay
   import phaser_pkg::*;
(
   input  logic              clk6x,
   input  logic              resetn,
   input  logic              cphi2_q_i,
   input  logic              cphi2_d_i,
   input  logic [VOFS_W-1:0] vofs_d_i,
   output logic              vphi2_o
);

   logic [DELAY_LEN-2:1] line_q;
   logic [DELAY_LEN-1:1] line_d;
   logic [DELAY_LEN-1:0] tap_d;
   logic                 vphi2_q;

   always_comb begin
      line_d = {line_q, cphi2_q_i};
      tap_d  = {line_d, cphi2_d_i};
   end

   always_ff @(posedge clk6x) begin
      if (!resetn) begin
         line_q  <= '1;
         vphi2_q <= 1'b1;
      end else begin
         line_q  <= line_d[DELAY_LEN-2:1];
         vphi2_q <= tap_d[vofs_d_i];
      end
   end

   assign vphi2_o = vphi2_q;

endmodule

// File: rtl/phaser_cfg.sv
// Programmable CPHI2/VPHI2 phase generator with stop point, stretch and shadowed config.
// Define PHASER_CYCLE_COUNT_EN to build the 32-bit CPU cycle counter on cyc_count_o.
//
// state | meaning
// LO    | cphi2 low, ucnt 0..lo-1, stop point at ucnt lo-2
// HI    | cphi2 high, ucnt 0..hi-1, stretchable at ucnt hi-1
module phaser_cfg
   import phaser_pkg::*;
#(
   parameter int CNT_W       = 4,
   parameter int DEF_LO      = PH_DEF_LO,
   parameter int DEF_HI      = PH_DEF_HI,
   parameter int DEF_VOFS    = PH_DEF_VOFS,
   parameter int MAX_STRETCH = 15
) (
   input  logic              clk6x,
   input  logic              resetn,
   input  logic              run_i,
   input  logic [CNT_W-1:0]  cfg_lo_i,
   input  logic [CNT_W-1:0]  cfg_hi_i,
   input  logic [2:0]        cfg_vofs_i,
   input  logic              cfg_load_i,
   input  logic              stretch_i,
   output logic              stopped_o,
   output logic              cphi2_o,
   output logic              vphi2_o,
   output logic              setup_cs_o,
   output logic              release_cs_o,
   output logic              stretch_ovf_o,
   output logic [31:0]       cyc_count_o
);

   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int SC_W    = (MAX_STRETCH > 0) ? $clog2(MAX_STRETCH + 1) : 1;

   logic              state_q, state_d;
   logic [CNT_W-1:0]  ucnt_q, ucnt_d;
   logic [CNT_W-1:0]  lo_q, lo_d, hi_q, hi_d;
   logic [VOFS_W-1:0] vofs_q, vofs_d;
   logic [CNT_W-1:0]  sh_lo_q, sh_lo_d, sh_hi_q, sh_hi_d;
   logic [VOFS_W-1:0] sh_vofs_q, sh_vofs_d;
   logic              pend_q, pend_d;
   logic [SC_W-1:0]   scnt_q, scnt_d;
   logic              hold, ovf;
   logic              cphi2_q, cphi2_d;
   logic              setup_q, setup_d;
   logic              rel_q, rel_d;
   logic              stop_q, ovf_q;

   always_comb begin
      state_d   = state_q;
      ucnt_d    = ucnt_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      vofs_d    = vofs_q;
      sh_lo_d   = sh_lo_q;
      sh_hi_d   = sh_hi_q;
      sh_vofs_d = sh_vofs_q;
      pend_d    = pend_q;
      scnt_d    = scnt_q;
      hold      = 1'b0;
      ovf       = 1'b0;

      if (state_q == ST_LO) begin
         if (ucnt_q == lo_q - CNT_W'(1)) begin
            state_d = ST_HI;
            ucnt_d  = '0;
         end else if (ucnt_q == lo_q - CNT_W'(2) && !run_i) begin
            hold = 1'b1;
         end else begin
            ucnt_d = ucnt_q + CNT_W'(1);
         end
      end else begin
         if (ucnt_q != hi_q - CNT_W'(1)) begin
            ucnt_d = ucnt_q + CNT_W'(1);
         end else if (stretch_i && scnt_q < SC_W'(MAX_STRETCH)) begin
            scnt_d = scnt_q + SC_W'(1);
         end else begin
            ovf     = stretch_i;
            state_d = ST_LO;
            ucnt_d  = '0;
            scnt_d  = '0;
            // Only swap timing at the boundary into LO ucnt 0 so no phase is cut short.
            if (pend_q) begin
               lo_d   = sh_lo_q;
               hi_d   = sh_hi_q;
               vofs_d = sh_vofs_q;
               pend_d = 1'b0;
            end
         end
      end

      if (cfg_load_i) begin
         sh_lo_d   = CNT_W'(clamp_range(int'(cfg_lo_i), 2, CNT_MAX));
         sh_hi_d   = CNT_W'(clamp_range(int'(cfg_hi_i), 1, CNT_MAX));
         sh_vofs_d = VOFS_W'(clamp_range(int'(cfg_vofs_i), 0,
                        vofs_limit(clamp_range(int'(cfg_lo_i), 2, CNT_MAX),
                                   clamp_range(int'(cfg_hi_i), 1, CNT_MAX))));
         pend_d    = 1'b1;
      end

      cphi2_d = (state_d == ST_HI);
      setup_d = (state_d == ST_LO) && (ucnt_d == lo_d - CNT_W'(1));
      rel_d   = (state_q == ST_HI) && (state_d == ST_LO);
   end

   always_ff @(posedge clk6x) begin
      if (!resetn) begin
         state_q   <= ST_LO;
         ucnt_q    <= '0;
         lo_q      <= CNT_W'(DEF_LO);
         hi_q      <= CNT_W'(DEF_HI);
         vofs_q    <= VOFS_W'(DEF_VOFS);
         sh_lo_q   <= CNT_W'(DEF_LO);
         sh_hi_q   <= CNT_W'(DEF_HI);
         sh_vofs_q <= VOFS_W'(DEF_VOFS);
         pend_q    <= 1'b0;
         scnt_q    <= '0;
         cphi2_q   <= 1'b0;
         setup_q   <= 1'b0;
         rel_q     <= 1'b0;
         stop_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ucnt_q    <= ucnt_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         vofs_q    <= vofs_d;
         sh_lo_q   <= sh_lo_d;
         sh_hi_q   <= sh_hi_d;
         sh_vofs_q <= sh_vofs_d;
         pend_q    <= pend_d;
         scnt_q    <= scnt_d;
         cphi2_q   <= cphi2_d;
         setup_q   <= setup_d;
         rel_q     <= rel_d;
         stop_q    <= hold;
         ovf_q     <= ovf;
      end
   end

   phase_delay u_delay (
      .clk6x     (clk6x),
      .resetn    (resetn),
      .cphi2_q_i (cphi2_q),
      .cphi2_d_i (cphi2_d),
      .vofs_d_i  (vofs_d),
      .vphi2_o   (vphi2_o)
   );

`ifdef PHASER_CYCLE_COUNT_EN
   logic [31:0] cyc_count_q;

   always_ff @(posedge clk6x) begin
      if (!resetn) begin
         cyc_count_q <= '0;
      end else if (state_q == ST_LO && state_d == ST_HI) begin
         cyc_count_q <= cyc_count_q + 32'd1;
      end
   end

   assign cyc_count_o = cyc_count_q;
`else
   assign cyc_count_o = '0;
`endif

   assign cphi2_o       = cphi2_q;
   assign setup_cs_o    = setup_q;
   assign release_cs_o  = rel_q;
   assign stopped_o     = stop_q;
   assign stretch_ovf_o = ovf_q;

endmodule

// File: tb/tb_phaser_cfg.sv
// Directed bench for phaser_cfg: vector table for the default/stop/reconfig sequence,
// hand sequences for clamp, stretch cap, mid-phase reset and the optional cycle counter.
module tb_phaser_cfg;

   logic        clk6x;
   logic        resetn;
   logic        run;
   logic [3:0]  cfg_lo;
   logic [3:0]  cfg_hi;
   logic [2:0]  cfg_vofs;
   logic        cfg_load;
   logic        stretch;
   logic        stopped;
   logic        cphi2;
   logic        vphi2;
   logic        setup_cs;
   logic        release_cs;
   logic        stretch_ovf;
   logic [31:0] cyc_count;

   int n_chk = 0;
   int n_err = 0;

   phaser_cfg dut (
      .clk6x         (clk6x),
      .resetn        (resetn),
      .run_i         (run),
      .cfg_lo_i      (cfg_lo),
      .cfg_hi_i      (cfg_hi),
      .cfg_vofs_i    (cfg_vofs),
      .cfg_load_i    (cfg_load),
      .stretch_i     (stretch),
      .stopped_o     (stopped),
      .cphi2_o       (cphi2),
      .vphi2_o       (vphi2),
      .setup_cs_o    (setup_cs),
      .release_cs_o  (release_cs),
      .stretch_ovf_o (stretch_ovf),
      .cyc_count_o   (cyc_count)
   );

   initial clk6x = 1'b0;
   always #5 clk6x = ~clk6x;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // {run, load, stretch, lo, hi, vofs} applied before an edge,
   // exp = {cphi2, vphi2, setup_cs, release_cs, stopped, stretch_ovf} after it.
   typedef struct {
      logic       run;
      logic       load;
      logic       str;
      logic [3:0] lo;
      logic [3:0] hi;
      logic [2:0] vofs;
      logic [5:0] exp;
   } vec_t;

   vec_t tv[$];

   task automatic tick();
      @(posedge clk6x);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] outs();
      return {cphi2, vphi2, setup_cs, release_cs, stopped, stretch_ovf};
   endfunction

   task automatic add(input logic r, input logic ld, input logic st, input logic [3:0] l,
                      input logic [3:0] h, input logic [2:0] vo, input logic [5:0] e);
      vec_t v;
      v.run = r; v.load = ld; v.str = st; v.lo = l; v.hi = h; v.vofs = vo; v.exp = e;
      tv.push_back(v);
   endtask

   task automatic do_reset();
      resetn   = 1'b0;
      run      = 1'b1;
      cfg_load = 1'b0;
      stretch  = 1'b0;
      cfg_lo   = 4'd0;
      cfg_hi   = 4'd0;
      cfg_vofs = 3'd0;
      tick();
      resetn = 1'b1;
   endtask

   logic [5:0]  h6_c, h6_v, h6_s, h6_r;
   logic [19:0] h20_c, h20_o, h20_r;
   logic [11:0] h12_c, h12_v;

   initial begin
      // default cycles, 5-clk stop, mid-HI reconfig to 4/2/3 (vofs clamps to 1)
      for (int i = 0; i < 2; i++) begin
         add(1, 0, 0, 0, 0, 0, 6'b000000);
         add(1, 0, 0, 0, 0, 0, 6'b001000);
         add(1, 0, 0, 0, 0, 0, 6'b100000);
         add(1, 0, 0, 0, 0, 0, 6'b110000);
         add(1, 0, 0, 0, 0, 0, 6'b110000);
         add(1, 0, 0, 0, 0, 0, 6'b010100);
      end
      add(1, 0, 0, 0, 0, 0, 6'b000000);
      for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 6'b000010);
      add(1, 0, 0, 0, 0, 0, 6'b001000);
      add(1, 0, 0, 0, 0, 0, 6'b100000);
      add(1, 1, 0, 4, 2, 3, 6'b110000);
      add(1, 0, 0, 0, 0, 0, 6'b110000);
      add(1, 0, 0, 0, 0, 0, 6'b010100);
      add(1, 0, 1, 0, 0, 0, 6'b000000);
      add(1, 0, 1, 0, 0, 0, 6'b000000);
      add(1, 0, 1, 0, 0, 0, 6'b001000);
      add(1, 0, 0, 0, 0, 0, 6'b100000);
      add(1, 0, 0, 0, 0, 0, 6'b110000);
      add(1, 0, 0, 0, 0, 0, 6'b010100);
      add(0, 0, 0, 0, 0, 0, 6'b000000);
      add(1, 0, 0, 0, 0, 0, 6'b000000);
      add(1, 0, 0, 0, 0, 0, 6'b001000);
      add(1, 0, 0, 0, 0, 0, 6'b100000);

      do_reset();
      chk("reset_outs", 32'(outs()), 32'h10);
      chk("reset_cyc", cyc_count, 32'd0);

      for (int i = 0; i < tv.size(); i++) begin
         run      = tv[i].run;
         cfg_load = tv[i].load;
         stretch  = tv[i].str;
         cfg_lo   = tv[i].lo;
         cfg_hi   = tv[i].hi;
         cfg_vofs = tv[i].vofs;
         tick();
         chk($sformatf("vec%0d", i + 1), 32'(outs()), 32'(tv[i].exp));
      end
      cfg_load = 1'b0;
      stretch  = 1'b0;
      run      = 1'b1;

      // two loads before apply: the second (0/0/7 -> 2/1/0) must win
      do_reset();
      cfg_load = 1'b1; cfg_lo = 4'd9; cfg_hi = 4'd9; cfg_vofs = 3'd0;
      tick();
      cfg_lo = 4'd0; cfg_hi = 4'd0; cfg_vofs = 3'd7;
      tick();
      cfg_load = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 6; i++) begin
         h6_c[i] = cphi2; h6_v[i] = vphi2; h6_s[i] = setup_cs; h6_r[i] = release_cs;
         if (i < 5) tick();
      end
      chk("clamp_cphi2", 32'(h6_c), 32'h24);
      chk("clamp_vphi2", 32'(h6_v), 32'h24);
      chk("clamp_setup", 32'(h6_s), 32'h12);
      chk("clamp_release", 32'(h6_r), 32'h09);

      // stretch held from HI ucnt 2: 3 + 15 high clk, one overflow pulse
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      stretch = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         h20_c[i] = cphi2; h20_o[i] = stretch_ovf; h20_r[i] = release_cs;
      end
      chk("stretch_cphi2", 32'(h20_c), 32'hC7FFF);
      chk("stretch_ovf", 32'(h20_o), 32'h08000);
      chk("stretch_release", 32'(h20_r), 32'h08000);
      stretch = 1'b0;
      tick();
      stretch = 1'b1;
      tick();
      chk("stretch_rearm", {30'd0, cphi2, stretch_ovf}, 32'h2);
      stretch = 1'b0;
      tick();
      chk("stretch_exit", {29'd0, cphi2, stretch_ovf, release_cs}, 32'h1);

      // reset at HI ucnt 1 with a pending 5/4/2 load
      do_reset();
      for (int i = 0; i < 3; i++) tick();
      cfg_load = 1'b1; cfg_lo = 4'd5; cfg_hi = 4'd4; cfg_vofs = 3'd2;
      tick();
      cfg_load = 1'b0;
      resetn   = 1'b0;
      tick();
      chk("midreset_outs", 32'(outs()), 32'h10);
      resetn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         h12_c[i] = cphi2; h12_v[i] = vphi2;
      end
      chk("midreset_cphi2", 32'(h12_c), 32'h71C);
      chk("midreset_vphi2", 32'(h12_v), 32'hE38);

`ifdef PHASER_CYCLE_COUNT_EN
      do_reset();
      chk("cnt_reset", cyc_count, 32'd0);
      for (int i = 0; i < 7; i++) tick();
      run = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("cnt_stopped", {31'd0, stopped}, 32'd1);
      chk("cnt_hold", cyc_count, 32'd1);
      run = 1'b1;
      for (int i = 0; i < 49; i++) tick();
      chk("cnt_nine", cyc_count, 32'd9);
      tick();
      chk("cnt_ten", cyc_count, 32'd10);
      force dut.cyc_count_q = 32'hFFFF_FFFF;
      tick();
      release dut.cyc_count_q;
      for (int i = 0; i < 4; i++) tick();
      chk("cnt_max", cyc_count, 32'hFFFF_FFFF);
      tick();
      chk("cnt_wrap", cyc_count, 32'd0);
`else
      chk("cnt_tied", cyc_count, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
